// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master wishbone arbiter.
//   arb_state_t : arbiter FSM states (idle, ownership per master, one-cycle
//                 arbiter-generated error per master)
//   cnt_width() : width of the wait-state counter for a given timeout limit
package wb_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OWN0  = 3'd1,
        OWN1  = 3'd2,
        TERR0 = 3'd3,
        TERR1 = 3'd4
    } arb_state_t;

    // A limit of 0 means "no timeout" but the counter still needs one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone classic bus bundle.
//   master modport : drives CYC, STB, WE, ADR, SEL, DAT_W; receives ACK, ERR, DAT_R
//   slave modport  : the mirror image
interface wb_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                    CYC;
    logic                    STB;
    logic                    WE;
    logic [ADDRESS_WIDTH-1:0] ADR;
    logic [DATA_WIDTH/8-1:0] SEL;
    logic [DATA_WIDTH-1:0]   DAT_W;
    logic [DATA_WIDTH-1:0]   DAT_R;
    logic                    ACK;
    logic                    ERR;

    modport master (
        output CYC, STB, WE, ADR, SEL, DAT_W,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  CYC, STB, WE, ADR, SEL, DAT_W,
        output DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_arbiter_2.sv
// Two-master wishbone arbiter in front of a single shared slave.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rstn : asynchronous active-low reset
//   m0   : master 0 request port (wins the first contention after reset)
//   m1   : master 1 request port
//   s    : shared downstream port
// Ownership is granted one cycle after CYC is seen in IDLE, alternates on
// contention, and lasts until the owner drops CYC.  A stalled owner (STB
// with no ACK/ERR for TIMEOUT cycles) gets a one-cycle arbiter ERR.
module wb_arbiter_2 #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic clk,
    input  logic rstn,
    wb_if.slave  m0,
    wb_if.slave  m1,
    wb_if.master s
);
    import wb_arbiter_pkg::*;

    localparam int                CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  W_LIMIT = CNT_W'(TIMEOUT);

    arb_state_t       r_state;
    logic             r_last_gnt;
    logic [CNT_W-1:0] r_wait_cnt;

    logic                      w_own0;
    logic                      w_own1;
    logic                      w_cyc;
    logic                      w_stb;
    logic                      w_we;
    logic [ADDRESS_WIDTH-1:0]  w_adr;
    logic [DATA_WIDTH/8-1:0]   w_sel;
    logic [DATA_WIDTH-1:0]     w_dat_w;
    logic                      w_stall;
    logic                      w_timeout;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);

    // Request mux: only the owner reaches the slave; IDLE/TERR present an idle bus.
    always_comb begin
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        w_we    = 1'b0;
        w_adr   = '0;
        w_sel   = '0;
        w_dat_w = '0;
        if (w_own0) begin
            w_cyc   = m0.CYC;
            w_stb   = m0.STB;
            w_we    = m0.WE;
            w_adr   = m0.ADR;
            w_sel   = m0.SEL;
            w_dat_w = m0.DAT_W;
        end else if (w_own1) begin
            w_cyc   = m1.CYC;
            w_stb   = m1.STB;
            w_we    = m1.WE;
            w_adr   = m1.ADR;
            w_sel   = m1.SEL;
            w_dat_w = m1.DAT_W;
        end
    end

    assign s.CYC   = w_cyc;
    assign s.STB   = w_stb;
    assign s.WE    = w_we;
    assign s.ADR   = w_adr;
    assign s.SEL   = w_sel;
    assign s.DAT_W = w_dat_w;

    // Responses reach only the owner; the arbiter ERR comes straight from the TERR state.
    assign m0.ACK   = w_own0 & s.ACK;
    assign m0.ERR   = (w_own0 & s.ERR) | (r_state == TERR0);
    assign m0.DAT_R = s.DAT_R;
    assign m1.ACK   = w_own1 & s.ACK;
    assign m1.ERR   = (w_own1 & s.ERR) | (r_state == TERR1);
    assign m1.DAT_R = s.DAT_R;

    // w_stb is already qualified by ownership, so this is an owner wait state.
    assign w_stall   = w_stb & ~s.ACK & ~s.ERR;
    // A response arriving in the limit cycle beats the timeout.
    assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == W_LIMIT) && !s.ACK && !s.ERR;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= '0;
                    if (m0.CYC && m1.CYC) begin
                        // Contention: the master not granted last time wins.
                        if (r_last_gnt) begin
                            r_state    <= OWN0;
                            r_last_gnt <= 1'b0;
                        end else begin
                            r_state    <= OWN1;
                            r_last_gnt <= 1'b1;
                        end
                    end else if (m0.CYC) begin
                        r_state    <= OWN0;
                        r_last_gnt <= 1'b0;
                    end else if (m1.CYC) begin
                        r_state    <= OWN1;
                        r_last_gnt <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (!w_cyc) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= w_own0 ? TERR0 : TERR1;
                        r_last_gnt <= w_own1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= w_stall ? r_wait_cnt + 1'b1 : '0;
                    end
                end
                TERR0, TERR1: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2.sv
module tb_wb_arbiter_2;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    wb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    wb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
    wb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) n0_if ();
    wb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) n1_if ();
    wb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ns_if ();

    wb_arbiter_2 #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .m0(m0_if), .m1(m1_if), .s(s_if)
    );

    wb_arbiter_2 #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rstn(rstn), .m0(n0_if), .m1(n1_if), .s(ns_if)
    );

    // Master drives: index 0 -> m0, 1 -> m1, 2 -> m0 of the no-timeout instance.
    logic        mc   [3];
    logic        ms   [3];
    logic        mw   [3];
    logic [31:0] ma   [3];
    logic [31:0] md   [3];
    logic [3:0]  msel [3];

    assign m0_if.CYC = mc[0]; assign m0_if.STB = ms[0]; assign m0_if.WE = mw[0];
    assign m0_if.ADR = ma[0]; assign m0_if.DAT_W = md[0]; assign m0_if.SEL = msel[0];
    assign m1_if.CYC = mc[1]; assign m1_if.STB = ms[1]; assign m1_if.WE = mw[1];
    assign m1_if.ADR = ma[1]; assign m1_if.DAT_W = md[1]; assign m1_if.SEL = msel[1];
    assign n0_if.CYC = mc[2]; assign n0_if.STB = ms[2]; assign n0_if.WE = mw[2];
    assign n0_if.ADR = ma[2]; assign n0_if.DAT_W = md[2]; assign n0_if.SEL = msel[2];
    assign n1_if.CYC = 1'b0;  assign n1_if.STB = 1'b0;  assign n1_if.WE = 1'b0;
    assign n1_if.ADR = '0;    assign n1_if.DAT_W = '0;  assign n1_if.SEL = '0;

    // SRAM-style slave behind the TIMEOUT=8 arbiter; ACK after slv_wait wait states.
    logic [31:0] mem [0:63];
    int          slv_wait;
    bit          slv_never;
    int          scnt;
    assign s_if.ERR = 1'b0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_if.ACK   <= 1'b0;
            s_if.DAT_R <= '0;
            scnt       <= 0;
            for (int k = 0; k < 64; k++) mem[k] <= 32'h5A00_0000 | k;
        end else begin
            s_if.ACK <= 1'b0;
            if (s_if.CYC && s_if.STB && !s_if.ACK) begin
                if (!slv_never && scnt >= slv_wait) begin
                    s_if.ACK <= 1'b1;
                    scnt     <= 0;
                    if (s_if.WE) begin
                        for (int b = 0; b < 4; b++)
                            if (s_if.SEL[b]) mem[s_if.ADR[7:2]][b*8 +: 8] <= s_if.DAT_W[b*8 +: 8];
                    end else begin
                        s_if.DAT_R <= mem[s_if.ADR[7:2]];
                    end
                end else begin
                    scnt <= scnt + 1;
                end
            end else begin
                scnt <= 0;
            end
        end
    end

    // Slow slave behind the TIMEOUT=0 arbiter: ACK after 1000 wait states.
    int ncnt;
    assign ns_if.ERR = 1'b0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ns_if.ACK   <= 1'b0;
            ns_if.DAT_R <= '0;
            ncnt        <= 0;
        end else begin
            ns_if.ACK <= 1'b0;
            if (ns_if.CYC && ns_if.STB && !ns_if.ACK) begin
                if (ncnt == 1000) begin
                    ns_if.ACK   <= 1'b1;
                    ns_if.DAT_R <= 32'hC0DE_0034;
                    ncnt        <= 0;
                end else begin
                    ncnt <= ncnt + 1;
                end
            end else begin
                ncnt <= 0;
            end
        end
    end

    typedef struct {
        int          id;
        bit          err;
        bit          chk;
        logic [31:0] dat;
    } exp_t;

    exp_t sbq[$];
    exp_t nq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic get_ack(input int id);
        case (id)
            0: return m0_if.ACK;
            1: return m1_if.ACK;
            2: return n0_if.ACK;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic get_err(input int id);
        case (id)
            0: return m0_if.ERR;
            1: return m1_if.ERR;
            2: return n0_if.ERR;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] get_dat(input int id);
        case (id)
            0: return m0_if.DAT_R;
            1: return m1_if.DAT_R;
            2: return n0_if.DAT_R;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input bit err, input bit c, input logic [31:0] d);
        exp_t e;
        e.id = id; e.err = err; e.chk = c; e.dat = d;
        return e;
    endfunction

    task automatic pop_cmp(input int id);
        exp_t e;
        logic a, r;
        logic [31:0] d;
        a = get_ack(id);
        r = get_err(id);
        d = get_dat(id);
        total++;
        if ((id < 2 && sbq.size() == 0) || (id == 2 && nq.size() == 0)) begin
            bad++;
            $display("FAIL resp_unexpected m%0d actual ack=%b err=%b required=no response", id, a, r);
        end else begin
            e = (id < 2) ? sbq.pop_front() : nq.pop_front();
            if (e.id != id || r !== e.err || a !== !e.err || (e.chk && d !== e.dat)) begin
                bad++;
                $display("FAIL resp_m%0d actual ack=%b err=%b dat=0x%08h required m%0d ack=%b err=%b dat=0x%08h",
                         id, a, r, d, e.id, !e.err, e.err, e.chk ? e.dat : d);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                for (int id = 0; id < 3; id++)
                    if (get_ack(id) === 1'b1 || get_err(id) === 1'b1) pop_cmp(id);
            end
        end
    endtask

    // One STB phase inside an already-open cycle; returns just after the edge
    // that follows the response, with STB dropped.
    task automatic wb_cycle(input int id, input bit we, input logic [31:0] adr, input logic [31:0] dat);
        bit got;
        ms[id] = 1'b1; mw[id] = we; ma[id] = adr; md[id] = dat; msel[id] = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (get_ack(id) === 1'b1 || get_err(id) === 1'b1) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wait_resp_m%0d actual=no response required=ACK or ERR", id);
        end
        @(posedge clk); #1;
        ms[id] = 1'b0;
    endtask

    initial begin
        int errcyc;
        int m1_seen;
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; ms[i] = 0; mw[i] = 0; ma[i] = '0; md[i] = '0; msel[i] = '0;
        end
        rstn = 1'b0;
        slv_wait = 0;
        slv_never = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_cyc", s_if.CYC, 0);
        chk("rst_s_stb", s_if.STB, 0);
        chk("rst_m0_ack", m0_if.ACK, 0);
        chk("rst_m1_err", m1_if.ERR, 0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(posedge clk); #1;

        // single write then read back, grant latency of one cycle
        sbq.push_back(mk(0, 0, 0, '0));
        mc[0] = 1; ms[0] = 1; mw[0] = 1; ma[0] = 32'h10; md[0] = 32'hDEADBEEF; msel[0] = 4'hF;
        @(negedge clk);
        chk("t029_idle_scyc", s_if.CYC, 0);
        @(negedge clk);
        chk("t029_grant_scyc", s_if.CYC, 1);
        chk("t029_fwd_adr", s_if.ADR, 32'h10);
        chk("t029_fwd_datw", s_if.DAT_W, 32'hDEADBEEF);
        wb_cycle(0, 1, 32'h10, 32'hDEADBEEF);
        sbq.push_back(mk(0, 0, 1, 32'hDEADBEEF));
        wb_cycle(0, 0, 32'h10, '0);
        mc[0] = 0;
        @(negedge clk);
        chk("t029_release_scyc", s_if.CYC, 0);

        // simultaneous request after reset: m0 first, then m1
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        sbq.push_back(mk(0, 0, 0, '0));
        sbq.push_back(mk(1, 0, 0, '0));
        mc[0] = 1; ms[0] = 1; mw[0] = 1; ma[0] = 32'h20; md[0] = 32'h30; msel[0] = 4'hF;
        mc[1] = 1; ms[1] = 1; mw[1] = 1; ma[1] = 32'h24; md[1] = 32'h31; msel[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("t030_m0_first", s_if.ADR, 32'h20);
        fork
            begin wb_cycle(0, 1, 32'h20, 32'h30); mc[0] = 0; end
            begin wb_cycle(1, 1, 32'h24, 32'h31); mc[1] = 0; end
        join

        // m0 holds ownership over four reads while m1 waits
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) sbq.push_back(mk(0, 0, 1, 32'h5A00_0000 + k));
        sbq.push_back(mk(1, 0, 1, 32'h31));
        m1_seen = 0;
        fork
            begin
                mc[0] = 1;
                for (int k = 0; k < 4; k++) wb_cycle(0, 0, 32'(k * 4), '0);
                mc[0] = 0;
            end
            begin
                @(posedge clk); #1;
                mc[1] = 1;
                wb_cycle(1, 0, 32'h24, '0);
                mc[1] = 0;
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 200 && mc[0]; i++) begin
                    if (s_if.CYC && s_if.ADR == 32'h24) m1_seen++;
                    @(negedge clk);
                end
                chk("t031_no_m1_grant", m1_seen, 0);
            end
        join

        // timeout: slave never acks, ERR one cycle, 10 cycles after STB rises
        slv_never = 1'b1;
        @(posedge clk); #1;
        sbq.push_back(mk(0, 1, 0, '0));
        mc[0] = 1; ms[0] = 1; mw[0] = 1; ma[0] = 32'h30; md[0] = 32'h1234; msel[0] = 4'hF;
        errcyc = -1;
        for (int i = 1; i <= 20 && errcyc < 0; i++) begin
            @(negedge clk);
            if (m0_if.ERR === 1'b1) begin
                errcyc = i;
                chk("t032_scyc_in_err", s_if.CYC, 0);
            end
        end
        chk("t032_err_cycle", errcyc, 11);
        @(posedge clk); #1;
        mc[0] = 0; ms[0] = 0;
        @(negedge clk);
        chk("t032_err_one_cycle", m0_if.ERR, 0);
        slv_never = 1'b0;

        // async reset while m1 is in a wait state
        slv_wait = 6;
        @(posedge clk); #1;
        mc[1] = 1; ms[1] = 1; mw[1] = 0; ma[1] = 32'h0; msel[1] = 4'hF;
        repeat (3) @(negedge clk);
        chk("t033_pre_scyc", s_if.CYC, 1);
        #1 rstn = 1'b0;
        #1;
        chk("t033_async_scyc", s_if.CYC, 0);
        chk("t033_async_sstb", s_if.STB, 0);
        chk("t033_async_m1_ack", m1_if.ACK, 0);
        chk("t033_async_m1_err", m1_if.ERR, 0);
        mc[1] = 0; ms[1] = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        slv_wait = 1;
        @(posedge clk); #1;
        sbq.push_back(mk(0, 0, 1, 32'h5A00_0002));
        sbq.push_back(mk(1, 0, 1, 32'h5A00_0003));
        mc[0] = 1; ms[0] = 1; mw[0] = 0; ma[0] = 32'h8; msel[0] = 4'hF;
        mc[1] = 1; ms[1] = 1; mw[1] = 0; ma[1] = 32'hC; msel[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("t033_m0_wins", s_if.ADR, 32'h8);
        fork
            begin wb_cycle(0, 0, 32'h8, '0); mc[0] = 0; end
            begin wb_cycle(1, 0, 32'hC, '0); mc[1] = 0; end
        join

        // timeout disabled: 1000 wait states end in ACK, never ERR
        @(posedge clk); #1;
        nq.push_back(mk(2, 0, 1, 32'hC0DE_0034));
        mc[2] = 1;
        wb_cycle(2, 0, 32'h40, '0);
        mc[2] = 0;

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        chk("nq_drained", nq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
